lane_gather: RTL



---
 rtl/lane_gather_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/lane_gather.sv | 77 +++++++
 3 files changed

// File: rtl/lane_gather_pkg.sv
// Shared defaults and types for the lane_gather block.
// Optional output parity is enabled with LANE_GATHER_PARITY_EN.
package lane_gather_pkg;

  localparam int SIZE_DEF  = 8;
  localparam int WIDTH_DEF = 8;
  localparam int LANE_W_DEF = $clog2(SIZE_DEF);

  typedef logic [LANE_W_DEF-1:0] lane_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] NW = (IW+1)'(N);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // ptr < N and offset < N, so one conditional subtract wraps the sum
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= NW)
        sum = sum - NW;
      idx = sum[IW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/lane_gather.sv
// Round-robin gather of SIZE lanes into one registered ready/valid stream.
// Define LANE_GATHER_PARITY_EN to add the registered o_parity output.
module lane_gather
  import lane_gather_pkg::*;
#(
  parameter int  SIZE   = SIZE_DEF,
  parameter int  WIDTH  = WIDTH_DEF,
  localparam int LANE_W = $clog2(SIZE)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [SIZE-1:0]            i_valid,
  input  logic [SIZE-1:0][WIDTH-1:0] i_data,
  output logic [SIZE-1:0]            o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [LANE_W-1:0]          o_lane,
`ifdef LANE_GATHER_PARITY_EN
  output logic                       o_parity,
`endif
  input  logic                       i_ready
);

  logic              load;
  logic              xfer;
  logic [SIZE-1:0]   grant;
  logic [LANE_W-1:0] gnt_idx;
  logic [LANE_W-1:0] ptr;
  logic [LANE_W-1:0] ptr_nxt;
  logic [WIDTH-1:0]  win_data;

  rr_arbiter #(
    .N(SIZE)
  ) u_arb (
    .req    (i_valid),
    .ptr    (ptr),
    .gnt    (grant),
    .gnt_idx(gnt_idx)
  );

  assign load = ~o_valid | i_ready;

  // reset gating keeps lanes from seeing an accept while held in reset
  assign o_ready = (load & i_arst_n) ? grant : '0;
  assign xfer    = |o_ready;

  assign win_data = i_data[gnt_idx];

  assign ptr_nxt = (gnt_idx == LANE_W'(SIZE-1)) ? '0
                                                : gnt_idx + 1'b1;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_lane  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      o_valid <= 1'b1;
      o_data  <= win_data;
      o_lane  <= gnt_idx;
      ptr     <= ptr_nxt;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef LANE_GATHER_PARITY_EN
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)
      o_parity <= 1'b0;
    else if (xfer)
      o_parity <= ^win_data;
  end
`endif

endmodule
